patch_embed_sched: RTL and testbench
====================================

# patch_embed_sched

Operand-sequencing controller for the patch-embedding stage. It walks every (patch, embedding-dim, pixel) triple of the projection and issues one operand-address beat per MAC step: image SRAM address, weight SRAM address, bias address, output address, and first/last accumulate flags. It sits between the top-level start/done control and a streaming multiply-accumulate pipeline. It then counts the pipeline's write-backs so that `done` reflects completed results, not just issued beats.

## Interface
- `IMG_H`, default 32: image height in pixels.
- `IMG_W`, default 32: image width in pixels.
- `C`, default 3: number of channels.
- `PH`, default 16: patch height.
- `PW`, default 16: patch width.
- `E`, default 8: embedding dimension.
- Derived values:
  - NP = (IMG_H/PH)·(IMG_W/PW).
  - PS = PH·PW·C.
  - IAW = $clog2(IMG_H·IMG_W·C).
  - WAW = $clog2(PS·E).
  - OAW = $clog2(NP·E).
- `clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle request; accepted only in IDLE.
- `abort`  in  1: synchronous cancel; wins over every other input.
- `busy`  out  1: high in ISSUE and DRAIN.
- `done`  out  1: one-cycle pulse when all NP·E results have been written back.
- `issue_valid`  out  1: operand beat is valid.
- `issue_ready`  in  1: MAC pipeline accepts the beat.
- `img_addr`  out  IAW: pixel index ((gy·IMG_W+gx)·C+ch).
- `w_addr`  out  WAW: weight index px·E+dim.
- `b_addr`  out  $clog2(E): bias index, equal to dim.
- `out_addr`  out  OAW: result index patch·E+dim.
- `acc_first`  out  1: first beat of a dot product; the MAC loads the bias.
- `acc_last`  out  1: last beat of a dot product; the MAC writes the result to out_addr.
- `res_valid`  in  1: one-cycle pulse per completed result from the MAC.

## Operation
- The state register has four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on `start`. All counters and `res_cnt` are cleared on this transition.
- Beat order uses nested counters, outermost first: patch_row, patch_col, dim, ly, lx, ch. ch is the fastest-moving counter.
  - No divide or modulo operations are used.
  - The pixel index px = (ly·PW+lx)·C+ch is kept as a running counter 0..PS-1.
- Address formulas:
  - gy = patch_row·PH+ly.
  - gx = patch_col·PW+lx.
  - img_addr = (gy·IMG_W+gx)·C+ch.
- Flags:
  - `acc_first` = (px==0).
  - `acc_last` = (px==PS-1).
  - `b_addr` and `out_addr` are valid on every beat. Consumers sample them on first and last beats respectively.
- Counters advance only on handshake (`issue_valid && issue_ready`).
- ISSUE → DRAIN on the handshake of the final beat (last patch, dim E-1, px PS-1).
- DRAIN:
  - `issue_valid` = 0.
  - Remains until `res_cnt == NP·E`.
  - → DONE on that condition.
- DONE → IDLE unconditionally, with `done` = 1 for that single cycle.
- `res_cnt` (width OAW+1) increments on `res_valid` in ISSUE and DRAIN. It saturates at NP·E; extra pulses are ignored.
- `res_valid` in IDLE or DONE is ignored.
- `abort` in any state → IDLE next cycle:
  - counters are cleared;
  - no `done` pulse;
  - `issue_valid` drops next cycle.
- `start` while busy or in DONE is ignored. It is not queued.

## Timing
- Reset values:
  - state IDLE.
  - `busy` = 0, `done` = 0, `issue_valid` = 0.
  - `acc_first` = 0, `acc_last` = 0.
  - All address outputs = 0.
  - `res_cnt` = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from `issue_ready` to any output.
- `start` at cycle T → `busy` and `issue_valid` high at T+1, with the beat for patch 0, dim 0, px 0.
- With `issue_ready` held high, one beat per cycle. NP·E·PS beats occupy cycles T+1 .. T+NP·E·PS.
- Handshake rules:
  - While `issue_valid && !issue_ready`, all address and flag outputs hold stable.
  - `issue_valid` never deasserts without a handshake, except on `abort` or reset.
- `done` rises the cycle after the clock edge where `res_cnt` reaches NP·E while in DRAIN. If the last `res_valid` arrives during ISSUE, DRAIN lasts exactly one cycle.
- `busy` falls in the same cycle that `done` rises.
- Asynchronous reset mid-operation forces the reset values immediately. After reset, `start` is required again.

## Test plan
Unless stated otherwise, all scenarios use IMG_H=IMG_W=4, C=1, PH=PW=2, E=2, so NP=4, PS=4, and there are 32 beats.

- **Nominal, ready tied high.**
  - Stimulus: `start` at T.
  - Beats 0-3: img_addr 0,1,4,5; w_addr 0,2,4,6; `acc_first` on beat 0, `acc_last` on beat 3 with out_addr 0.
  - Beats 4-7: img_addr 0,1,4,5; w_addr 1,3,5,7; out_addr 1.
  - Patch 1 img_addr 2,3,6,7. Patch 2 img_addr 8,9,12,13. Patch 3 img_addr 10,11,14,15, with out_addr 6 then 7.
  - The final beat is issued at T+32.
- **Backpressure.**
  - Stimulus: `issue_ready` random at 50%.
  - Required: the beat sequence matches the nominal case exactly; outputs are stable during stall cycles; exactly 32 handshakes occur.
- **Result counting.**
  - Stimulus: `res_valid` pulses delayed by 5 cycles after each `acc_last` handshake.
  - Required: `done` is a single pulse one cycle after the 8th `res_valid`; `busy` = 0 afterwards.
  - Extra `res_valid` pulses after the 8th produce no second `done`.
- **Abort mid-issue.**
  - Stimulus: `abort` after beat 13.
  - Required: IDLE next cycle; `issue_valid` = 0; no `done`.
  - A subsequent `start` restarts at img_addr 0, w_addr 0.
- **Start while busy, and reset mid-DRAIN.**
  - Stimulus: `start` during ISSUE.
  - Required: ignored, and the beat sequence is unchanged.
  - Stimulus: `rst_n` low in DRAIN.
  - Required: all outputs 0 immediately.
- **Channels > 1.**
  - Parameters: C=3, IMG 4x4, PH=PW=2, E=1.
  - Required: patch 0 img_addr sequence is 0,1,2,3,4,5,12,13,14,15,16,17; w_addr 0..11.

Source files
------------

// File: rtl/patch_embed_if.sv
// patch_embed_if: start/done control plus operand-issue and result handshake bundle.
interface patch_embed_if #(
  parameter int IMG_H = 32,
  parameter int IMG_W = 32,
  parameter int C     = 3,
  parameter int PH    = 16,
  parameter int PW    = 16,
  parameter int E     = 8
);
  localparam int NP  = (IMG_H / PH) * (IMG_W / PW);
  localparam int PS  = PH * PW * C;
  localparam int IAW = $clog2(IMG_H * IMG_W * C);
  localparam int WAW = $clog2(PS * E);
  localparam int OAW = $clog2(NP * E);
  localparam int BW  = E > 1 ? $clog2(E) : 1;
  logic           start;
  logic           abort;
  logic           busy;
  logic           done;
  logic           issue_valid;
  logic           issue_ready;
  logic [IAW-1:0] img_addr;
  logic [WAW-1:0] w_addr;
  logic [BW-1:0]  b_addr;
  logic [OAW-1:0] out_addr;
  logic           acc_first;
  logic           acc_last;
  logic           res_valid;
  modport master (
    input  start, abort, issue_ready, res_valid,
    output busy, done, issue_valid, img_addr, w_addr, b_addr, out_addr, acc_first, acc_last
  );
  modport slave (
    output start, abort, issue_ready, res_valid,
    input  busy, done, issue_valid, img_addr, w_addr, b_addr, out_addr, acc_first, acc_last
  );
endinterface

// File: rtl/patch_embed_sched.sv
// patch_embed_sched: walks (patch, dim, pixel) MAC operands and counts write-backs before done.
module patch_embed_sched #(
  parameter int IMG_H = 32,
  parameter int IMG_W = 32,
  parameter int C     = 3,
  parameter int PH    = 16,
  parameter int PW    = 16,
  parameter int E     = 8
) (
  input  logic clk,
  input  logic rst_n,
  patch_embed_if.master bus
);
  localparam int NPR = IMG_H / PH;
  localparam int NPC = IMG_W / PW;
  localparam int NP  = NPR * NPC;
  localparam int PS  = PH * PW * C;
  localparam int NPE = NP * E;
  localparam int IAW = $clog2(IMG_H * IMG_W * C);
  localparam int WAW = $clog2(PS * E);
  localparam int OAW = $clog2(NPE);
  localparam int RCW = OAW + 1;
  localparam int RW  = NPR > 1 ? $clog2(NPR) : 1;
  localparam int CW  = NPC > 1 ? $clog2(NPC) : 1;
  localparam int DW  = E > 1 ? $clog2(E) : 1;
  localparam int LYW = PH > 1 ? $clog2(PH) : 1;
  localparam int LXW = PW > 1 ? $clog2(PW) : 1;
  localparam int CHW = C > 1 ? $clog2(C) : 1;
  localparam int PXW = PS > 1 ? $clog2(PS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t         state_q, state_d;
  logic [RW-1:0]  pr_q, pr_d;
  logic [CW-1:0]  pc_q, pc_d;
  logic [DW-1:0]  dim_q, dim_d;
  logic [LYW-1:0] ly_q, ly_d;
  logic [LXW-1:0] lx_q, lx_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [PXW-1:0] px_q, px_d;
  logic [RCW-1:0] res_cnt_q, res_cnt_d;
  logic hs, clr, w_ch, w_lx, w_ly, w_dim, w_pc, fin;
  // each w_* means "this counter and every faster one wrap on this beat"
  always_comb begin
    hs        = state_q == ISSUE && bus.issue_ready;
    clr       = bus.abort || (state_q == IDLE && bus.start);
    w_ch      = ch_q == CHW'(C - 1);
    w_lx      = w_ch && lx_q == LXW'(PW - 1);
    w_ly      = w_lx && ly_q == LYW'(PH - 1);
    w_dim     = w_ly && dim_q == DW'(E - 1);
    w_pc      = w_dim && pc_q == CW'(NPC - 1);
    fin       = w_pc && pr_q == RW'(NPR - 1);
    ch_d      = clr ? '0 : hs ? (w_ch ? '0 : ch_q + 1'b1) : ch_q;
    lx_d      = clr ? '0 : hs && w_ch ? (w_lx ? '0 : lx_q + 1'b1) : lx_q;
    ly_d      = clr ? '0 : hs && w_lx ? (w_ly ? '0 : ly_q + 1'b1) : ly_q;
    px_d      = clr ? '0 : hs ? (w_ly ? '0 : px_q + 1'b1) : px_q;
    dim_d     = clr ? '0 : hs && w_ly ? (w_dim ? '0 : dim_q + 1'b1) : dim_q;
    pc_d      = clr ? '0 : hs && w_dim ? (w_pc ? '0 : pc_q + 1'b1) : pc_q;
    pr_d      = clr ? '0 : hs && w_pc ? (fin ? '0 : pr_q + 1'b1) : pr_q;
    res_cnt_d = clr ? '0 : (state_q == ISSUE || state_q == DRAIN) && bus.res_valid && res_cnt_q != RCW'(NPE) ? res_cnt_q + 1'b1 : res_cnt_q;
    state_d   = bus.abort ? IDLE :
                state_q == IDLE  ? (bus.start ? ISSUE : IDLE) :
                state_q == ISSUE ? (hs && fin ? DRAIN : ISSUE) :
                state_q == DRAIN ? (res_cnt_d == RCW'(NPE) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pr_q      <= '0;
      pc_q      <= '0;
      dim_q     <= '0;
      ly_q      <= '0;
      lx_q      <= '0;
      ch_q      <= '0;
      px_q      <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pr_q      <= pr_d;
      pc_q      <= pc_d;
      dim_q     <= dim_d;
      ly_q      <= ly_d;
      lx_q      <= lx_d;
      ch_q      <= ch_d;
      px_q      <= px_d;
      res_cnt_q <= res_cnt_d;
    end
  end
  assign bus.busy        = state_q == ISSUE || state_q == DRAIN;
  assign bus.issue_valid = state_q == ISSUE;
  assign bus.done        = state_q == DONE;
  assign bus.acc_first   = state_q == ISSUE && px_q == '0;
  assign bus.acc_last    = state_q == ISSUE && px_q == PXW'(PS - 1);
  assign bus.img_addr    = IAW'(((int'(pr_q) * PH + int'(ly_q)) * IMG_W + int'(pc_q) * PW + int'(lx_q)) * C + int'(ch_q));
  assign bus.w_addr      = WAW'(int'(px_q) * E + int'(dim_q));
  assign bus.b_addr      = dim_q;
  assign bus.out_addr    = OAW'((int'(pr_q) * NPC + int'(pc_q)) * E + int'(dim_q));
endmodule

// File: tb/tb_patch_embed_sched.sv
// tb_patch_embed_sched: directed checks of beat order, backpressure, result counting, abort and reset.
module tb_patch_embed_sched;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  patch_embed_if #(.IMG_H(4), .IMG_W(4), .C(1), .PH(2), .PW(2), .E(2)) b1 ();
  patch_embed_if #(.IMG_H(4), .IMG_W(4), .C(3), .PH(2), .PW(2), .E(1)) b2 ();
  patch_embed_sched #(.IMG_H(4), .IMG_W(4), .C(1), .PH(2), .PW(2), .E(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  patch_embed_sched #(.IMG_H(4), .IMG_W(4), .C(3), .PH(2), .PW(2), .E(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  int vecs = 0;
  int miss = 0;
  int patch_base[4] = '{0, 2, 8, 10};
  int pix_off[4]    = '{0, 1, 4, 5};
  int ch_img[12]    = '{0, 1, 2, 3, 4, 5, 12, 13, 14, 15, 16, 17};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_beat(input int b);
    int p, d, x;
    p = b / 8;
    d = (b / 4) % 2;
    x = b % 4;
    chk($sformatf("valid[%0d]", b), b1.issue_valid, 1);
    chk($sformatf("img[%0d]", b), b1.img_addr, patch_base[p] + pix_off[x]);
    chk($sformatf("w[%0d]", b), b1.w_addr, x * 2 + d);
    chk($sformatf("bias[%0d]", b), b1.b_addr, d);
    chk($sformatf("out[%0d]", b), b1.out_addr, p * 2 + d);
    chk($sformatf("first[%0d]", b), b1.acc_first, x == 0);
    chk($sformatf("last[%0d]", b), b1.acc_last, x == 3);
  endtask
  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, b1.busy, 0);
    chk({tag, "_done"}, b1.done, 0);
    chk({tag, "_valid"}, b1.issue_valid, 0);
    chk({tag, "_first"}, b1.acc_first, 0);
    chk({tag, "_last"}, b1.acc_last, 0);
    chk({tag, "_img"}, b1.img_addr, 0);
    chk({tag, "_w"}, b1.w_addr, 0);
    chk({tag, "_bias"}, b1.b_addr, 0);
    chk({tag, "_out"}, b1.out_addr, 0);
  endtask
  task automatic run(input bit rnd, input int start_again);
    int hs, rv, done_cyc;
    int due[$];
    bit stalled;
    logic [31:0] p_img, p_w, p_out;
    hs = 0;
    rv = 0;
    done_cyc = -1;
    stalled = 0;
    p_img = 0;
    p_w = 0;
    p_out = 0;
    b1.start = 1;
    b1.issue_ready = 0;
    for (int cyc = 1; cyc < 600; cyc++) begin
      @(negedge clk);
      b1.start = (cyc == start_again);
      if (hs < 32) begin
        check_beat(hs);
        if (!rnd) chk("nom_time", hs, cyc - 1);
      end else chk("valid_after_last", b1.issue_valid, 0);
      if (stalled) begin
        chk("stall_img", b1.img_addr, p_img);
        chk("stall_w", b1.w_addr, p_w);
        chk("stall_out", b1.out_addr, p_out);
      end
      chk("done", b1.done, cyc == done_cyc);
      chk("busy", b1.busy, done_cyc < 0 || cyc < done_cyc);
      if (done_cyc > 0 && cyc == done_cyc + 4) break;
      b1.res_valid = 0;
      if (due.size() > 0 && due[0] == cyc) begin
        void'(due.pop_front());
        b1.res_valid = 1;
        rv++;
        if (rv == 8) done_cyc = cyc + 1;
      end
      if (done_cyc > 0 && (cyc == done_cyc || cyc == done_cyc + 1)) b1.res_valid = 1;
      b1.issue_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = b1.issue_valid && !b1.issue_ready;
      p_img = b1.img_addr;
      p_w = b1.w_addr;
      p_out = b1.out_addr;
      if (b1.issue_valid && b1.issue_ready) begin
        if (b1.acc_last) due.push_back(cyc + 5);
        hs++;
      end
    end
    b1.res_valid = 0;
    b1.issue_ready = 0;
    chk("handshakes", hs, 32);
    chk("done_seen", done_cyc > 0, 1);
  endtask
  initial begin
    b1.start = 0; b1.abort = 0; b1.issue_ready = 0; b1.res_valid = 0;
    b2.start = 0; b2.abort = 0; b2.issue_ready = 0; b2.res_valid = 0;
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    b2.start = 1;
    b2.issue_ready = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      b2.start = 0;
      chk($sformatf("ch_valid[%0d]", i), b2.issue_valid, 1);
      chk($sformatf("ch_img[%0d]", i), b2.img_addr, ch_img[i]);
      chk($sformatf("ch_w[%0d]", i), b2.w_addr, i);
    end
    b2.abort = 1;
    @(negedge clk);
    b2.abort = 0;
    b2.issue_ready = 0;
    chk("ch_abort_valid", b2.issue_valid, 0);
    run(0, 0);
    run(1, 7);
    @(negedge clk);
    b1.start = 1;
    b1.issue_ready = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      b1.start = 0;
      check_beat(i);
    end
    @(negedge clk);
    b1.abort = 1;
    @(negedge clk);
    b1.abort = 0;
    chk("abort_valid", b1.issue_valid, 0);
    chk("abort_busy", b1.busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", b1.done, 0);
      chk("abort_idle", b1.issue_valid, 0);
    end
    b1.start = 1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      b1.start = 0;
      check_beat(i);
    end
    @(negedge clk);
    chk("drain_busy", b1.busy, 1);
    chk("drain_valid", b1.issue_valid, 0);
    #2 rst_n = 0;
    #1 check_idle_zero("rst_drain");
    @(negedge clk);
    rst_n = 1;
    b1.issue_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", b1.issue_valid, 0);
      chk("post_rst_busy", b1.busy, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
